// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared word width and FSM state encoding for the memory responder
package mem_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10,
    ST_ERR  = 2'b11
  } mem_state_e;
endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/acknowledge bus between initiator and responder
// mem_err exists only when MEM_RESPONDER_ERR_EN is defined.
interface mem_responder_if;
  import mem_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_write_data;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_read_data;
  logic [1:0]        state;
`ifdef MEM_RESPONDER_ERR_EN
  logic              mem_err;

  modport master (output mem_read, mem_write, mem_addr, mem_write_data,
                  input  mem_ack, mem_read_data, state, mem_err);
  modport slave  (input  mem_read, mem_write, mem_addr, mem_write_data,
                  output mem_ack, mem_read_data, state, mem_err);
`else
  modport master (output mem_read, mem_write, mem_addr, mem_write_data,
                  input  mem_ack, mem_read_data, state);
  modport slave  (input  mem_read, mem_write, mem_addr, mem_write_data,
                  output mem_ack, mem_read_data, state);
`endif
endinterface

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - single-port word storage, synchronous write, asynchronous read
module mem_responder_array
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WORD_W-1:0]     i_wdata,
  output logic [WORD_W-1:0]     o_rdata
);
  // Contents are deliberately left out of reset.
  logic [WORD_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with one-cycle acknowledge
// Define MEM_RESPONDER_ERR_EN to reject out-of-range or read+write requests with mem_err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_e            r_state;
  mem_state_e            w_next;
  logic [3:0]            r_wait_cnt;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [WORD_W-1:0]     r_wdata;
  logic [WORD_W-1:0]     r_rdata;
  logic                  r_is_write;
  logic                  w_req;
  logic                  w_bad_req;
  logic                  w_we;
  logic [WORD_W-1:0]     w_rd_word;

  assign w_req = bus.mem_read | bus.mem_write;

`ifdef MEM_RESPONDER_ERR_EN
  assign w_bad_req = (|bus.mem_addr[WORD_W-1:DEPTH_LOG2]) | (bus.mem_read & bus.mem_write);
  assign bus.mem_err = (r_state == ST_ERR);
`else
  logic w_unused_hi;
  assign w_bad_req   = 1'b0;
  assign w_unused_hi = ^bus.mem_addr[WORD_W-1:DEPTH_LOG2];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_bad_req)             w_next = ST_ERR;
          else if (WAIT_CYCLES == 0) w_next = ST_ACK;
          else                       w_next = ST_WAIT;
        end
      end
      // Dropping both requests while waiting abandons the transfer.
      ST_WAIT: begin
        if (!w_req)                w_next = ST_IDLE;
        else if (r_wait_cnt == 0)  w_next = ST_ACK;
      end
      ST_ACK:  w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (r_state == ST_IDLE && w_req) begin
        r_addr     <= bus.mem_addr[DEPTH_LOG2-1:0];
        r_wdata    <= bus.mem_write_data;
        r_is_write <= bus.mem_write;
        r_wait_cnt <= WAIT_LOAD;
      end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (r_state == ST_ACK && !r_is_write) r_rdata <= w_rd_word;
    end
  end

  assign w_we = (r_state == ST_ACK) & r_is_write;

  mem_responder_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rd_word)
  );

  assign bus.mem_ack       = (r_state == ST_ACK) || (r_state == ST_ERR);
  assign bus.mem_read_data = (r_state == ST_ACK && !r_is_write) ? w_rd_word : r_rdata;
  assign bus.state         = r_state;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized model-checked bench for three responders (0/1/3 wait states)
module tb_mem_responder;
`ifdef MEM_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  int          r_sel;
  int          n_tests = 0;
  int          n_fail  = 0;

  int          W_OF [3] = '{0, 1, 3};
  logic [31:0] m_mem   [3][256];
  bit          m_known [3][256];
  logic [31:0] m_hold  [3];

  logic        w_ack;
  logic [31:0] w_rdata;
  logic [1:0]  w_state;
  logic        w_err;

  always #5 clk = ~clk;

  mem_responder_if u_if0 ();
  mem_responder_if u_if1 ();
  mem_responder_if u_if2 ();

  assign u_if0.mem_read  = d_read  && (r_sel == 0);
  assign u_if0.mem_write = d_write && (r_sel == 0);
  assign u_if1.mem_read  = d_read  && (r_sel == 1);
  assign u_if1.mem_write = d_write && (r_sel == 1);
  assign u_if2.mem_read  = d_read  && (r_sel == 2);
  assign u_if2.mem_write = d_write && (r_sel == 2);
  assign u_if0.mem_addr = d_addr;  assign u_if0.mem_write_data = d_wdata;
  assign u_if1.mem_addr = d_addr;  assign u_if1.mem_write_data = d_wdata;
  assign u_if2.mem_addr = d_addr;  assign u_if2.mem_write_data = d_wdata;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(u_if0.slave));
  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(u_if1.slave));
  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(3)) u_dut2 (.clk(clk), .reset(reset), .bus(u_if2.slave));

  always_comb begin
    w_ack = u_if0.mem_ack; w_rdata = u_if0.mem_read_data; w_state = u_if0.state;
    if (r_sel == 1) begin
      w_ack = u_if1.mem_ack; w_rdata = u_if1.mem_read_data; w_state = u_if1.state;
    end else if (r_sel == 2) begin
      w_ack = u_if2.mem_ack; w_rdata = u_if2.mem_read_data; w_state = u_if2.state;
    end
`ifdef MEM_RESPONDER_ERR_EN
    w_err = (r_sel == 0) ? u_if0.mem_err : (r_sel == 1) ? u_if1.mem_err : u_if2.mem_err;
`else
    w_err = 1'b0;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction with latency, data, error, single-cycle ack and hold checks.
  task automatic run_txn(input int sel, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag);
    bit       exp_err;
    int       exp_lat, n;
    bit       got_ack;
    int       idx;
    exp_err = ERR_EN && ((addr[31:8] != 24'd0) || (rd && wr));
    exp_lat = exp_err ? 1 : 1 + W_OF[sel];
    idx     = int'(addr[7:0]);
    r_sel = sel; d_read = rd; d_write = wr; d_addr = addr; d_wdata = wd;
    n = 0; got_ack = 0;
    while (n < 40 && !got_ack) begin
      @(posedge clk); #1;
      n++;
      if (w_ack) got_ack = 1;
      else begin
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    if (got_ack) begin
      if (ERR_EN) check({tag, "_err"}, 32'(w_err), 32'(exp_err));
      if (rd && !wr && !exp_err) begin
        check({tag, "_rdata"}, w_rdata, m_mem[sel][idx]);
        m_hold[sel] = m_mem[sel][idx];
      end
    end
    d_read = 0; d_write = 0;
    @(posedge clk); #1;
    check({tag, "_ack1cyc"}, 32'(w_ack), 32'd0);
    check({tag, "_idle"}, 32'(w_state), 32'd0);
    check({tag, "_hold"}, w_rdata, m_hold[sel]);
    if (!exp_err && wr) begin
      m_mem[sel][idx]   = wd;
      m_known[sel][idx] = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v_old, a, w;
    int          k, cyc;
    bit          saw_ack;
    reset = 1; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0; r_sel = 0;
    for (int s = 0; s < 3; s++) m_hold[s] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      r_sel = s; #1;
      check("rst_state", 32'(w_state), 32'd0);
      check("rst_ack", 32'(w_ack), 32'd0);
      check("rst_rdata", w_rdata, 32'd0);
    end
    @(posedge clk); #1;
    reset = 0;

    run_txn(1, 0, 1, 32'd5, 32'hDEADBEEF, "basic_wr");
    run_txn(1, 1, 0, 32'd5, 32'h0, "basic_rd");

    for (int i = 0; i < 4; i++) run_txn(0, 0, 1, 32'(i), $urandom, "pre_stream");
    r_sel = 0; d_read = 1; d_addr = 0; k = 0; cyc = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (w_ack) begin
        check("stream_gap", 32'(cyc), (k == 0) ? 32'd1 : 32'd2);
        check("stream_rdata", w_rdata, m_mem[0][k]);
        m_hold[0] = m_mem[0][k];
        k++; d_addr = 32'(k); cyc = 0;
        if (k == 4) d_read = 0;
      end
    end
    d_read = 0;
    check("stream_count", 32'(k), 32'd4);
    @(posedge clk); #1;

    a = 32'($urandom_range(0, 255)); v_old = $urandom;
    run_txn(2, 0, 1, a, v_old, "abort_pre");
    r_sel = 2; d_write = 1; d_addr = a; d_wdata = ~v_old;
    @(posedge clk); #1;
    check("abort_in_wait", 32'(w_state), 32'd1);
    @(posedge clk); #1;
    d_write = 0; saw_ack = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (w_ack) saw_ack = 1;
    end
    check("abort_no_ack", 32'(saw_ack), 32'd0);
    check("abort_idle", 32'(w_state), 32'd0);
    run_txn(2, 1, 0, a, 32'h0, "abort_rd");

    a = 32'($urandom_range(0, 255)); v_old = $urandom;
    run_txn(2, 0, 1, a, v_old, "rst_pre");
    run_txn(2, 1, 0, a, 32'h0, "rst_pre_rd");
    r_sel = 2; d_write = 1; d_addr = a; d_wdata = ~v_old;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; #1;
    check("midrst_state", 32'(w_state), 32'd0);
    check("midrst_ack", 32'(w_ack), 32'd0);
    check("midrst_rdata", w_rdata, 32'd0);
    for (int s = 0; s < 3; s++) m_hold[s] = 32'd0;
    d_write = 0;
    @(posedge clk); #1;
    reset = 0;
    run_txn(2, 1, 0, a, 32'h0, "midrst_rd");

    run_txn(1, 0, 1, 32'd0, $urandom, "alias_pre");
    run_txn(1, 0, 1, 32'h100, $urandom, "alias_wr");
    run_txn(1, 1, 0, 32'd0, 32'h0, "alias_rd");

    a = 32'($urandom_range(0, 255));
    run_txn(1, 0, 1, a, $urandom, "both_pre");
    run_txn(1, 1, 1, a, $urandom, "both_wr");
    run_txn(1, 1, 0, a, 32'h0, "both_rd");

    for (int i = 0; i < 60; i++) begin
      int  s, op;
      bit  rd, wr;
      s  = $urandom_range(0, 2);
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a[31:8] = 24'($urandom_range(1, 255));
      op = $urandom_range(0, 7);
      rd = (op >= 3);
      wr = (op <= 2) || (op == 7);
      if (rd && !wr && !m_known[s][a[7:0]]) begin rd = 0; wr = 1; end
      w = $urandom;
      run_txn(s, rd, wr, a, w, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 8, meaning the storage holds 2^DEPTH_LOG2 32-bit words.
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning the number of wait states inserted before acknowledge.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port mem_read, input, 1 bit: read request, held high by the initiator until acknowledged.
REQ-006 The module SHALL have port mem_write, input, 1 bit: write request, held high by the initiator until acknowledged.
REQ-007 The module SHALL have port mem_addr, input, 32 bits: word address.
REQ-008 The module SHALL have port mem_write_data, input, 32 bits: write data.
REQ-009 The module SHALL have port mem_ack, output, 1 bit: one-cycle completion pulse.
REQ-010 The module SHALL have port mem_read_data, output, 32 bits: read data, valid in the mem_ack cycle of a read.
REQ-011 The module SHALL have port state, output, 2 bits: current FSM state, for debug.

Function
REQ-012 The FSM SHALL have four states: IDLE=00, WAIT=01, ACK=10, ERR=11 (ERR is reachable only with the REQ-025 macro defined).
REQ-013 In IDLE, when mem_read or mem_write is high, the module SHALL latch mem_addr[DEPTH_LOG2-1:0], mem_write_data and the operation type, then enter WAIT (WAIT_CYCLES>0) or ACK (WAIT_CYCLES=0).
REQ-014 The wait counter SHALL load WAIT_CYCLES-1 on entry to WAIT, decrement each cycle, and move to ACK in the cycle after it reads 0.
REQ-015 In ACK, mem_ack SHALL be high for exactly one cycle; writes SHALL commit to storage on that edge; mem_read_data SHALL hold the latched-address word.
REQ-016 Request-to-ack latency SHALL be 1+WAIT_CYCLES cycles, measured from the cycle the request is sampled in IDLE.
REQ-017 ACK SHALL always return to IDLE; a request still asserted in the cycle after ACK SHALL be accepted as a new transaction, so back-to-back streaming achieves one transfer per 2+WAIT_CYCLES cycles.
REQ-018 If both requests go low during WAIT, the module SHALL abort to IDLE with no ack and no storage write.
REQ-019 Changes to mem_addr or mem_write_data after acceptance SHALL be ignored.
REQ-020 Address bits [31:DEPTH_LOG2] SHALL be ignored, so addresses wrap modulo 2^DEPTH_LOG2, unless the REQ-025 macro is defined.
REQ-021 When mem_read and mem_write are both high in IDLE, the module SHALL perform the write.
REQ-022 mem_read_data SHALL hold its last value outside ACK cycles.

Reset
REQ-023 On reset assertion, the module SHALL immediately set state=IDLE, mem_ack=0, mem_read_data=0 and the wait counter to 0, and SHALL clear mem_err when present.
REQ-024 Reset asserted mid-transaction SHALL discard that transaction with no write; storage contents SHALL NOT be reset.

Configuration
REQ-025 With macro MEM_RESPONDER_ERR_EN defined, the module SHALL add an output port mem_err, 1 bit, and SHALL apply REQ-026 and REQ-027.
REQ-026 With MEM_RESPONDER_ERR_EN defined, a request that has a nonzero address in bits [31:DEPTH_LOG2], or both mem_read and mem_write high, SHALL enter ERR: mem_ack and mem_err are high together for one cycle, no storage write occurs, and mem_read_data is unchanged.
REQ-027 With MEM_RESPONDER_ERR_EN defined, ERR SHALL return to IDLE after its one cycle.
REQ-028 Without MEM_RESPONDER_ERR_EN, the mem_err port and the ERR state SHALL be absent, and REQ-020 and REQ-021 SHALL apply.

Structure
REQ-029 Shared package mem_pkg SHALL hold the WORD_W=32 constant and the state encoding enum, both reused by the cpu-side logic.
REQ-030 Storage SHALL be a sub-module mem_responder_array: single-port, synchronous write, asynchronous read, parameterised by DEPTH_LOG2.

Verification
REQ-031 The bench SHALL cover: WAIT_CYCLES=1, write 0xDEADBEEF to address 5, then read address 5 -> each mem_ack comes 2 cycles after its request, read data is 0xDEADBEEF.
REQ-032 The bench SHALL cover: mem_read held high continuously while the address increments on each ack, 4 transfers at WAIT_CYCLES=0 -> ack every 2nd cycle, data from addresses 0,1,2,3.
REQ-033 The bench SHALL cover: write request dropped during WAIT with WAIT_CYCLES=3 -> no ack, and a later read of that address returns the old value.
REQ-034 The bench SHALL cover: reset pulsed mid-WAIT -> state=00 and mem_ack=0 immediately, with no write committed.
REQ-035 The bench SHALL cover: address 0x100 with DEPTH_LOG2=8 -> aliases to word 0 without the macro; with MEM_RESPONDER_ERR_EN defined, mem_err and mem_ack are high for 1 cycle and storage is untouched.
REQ-036 The bench SHALL cover: mem_read and mem_write both high -> write performed without the macro; error response with MEM_RESPONDER_ERR_EN defined.
